div_seq: RTL and testbench

//  Multi-cycle 32-bit divider sequencer for the EX stage (DIV/DIVU). Accepts one operation from EX,

---
 rtl/div_seq.sv | 124 ++++++++++++
 tb/tb_div_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for EX-stage DIV/DIVU.
// Returns {remainder, quotient}; EX stalls while the block is busy.
module div_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  typedef enum logic [1:0] {
    S_FREE,
    S_BYZERO,
    S_ON,
    S_END
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] dvd;
  logic [DATA_W-1:0] dsr;
  logic [DATA_W-1:0] rem;
  logic              neg_q;
  logic              neg_r;

  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W:0]   rem_sh;
  logic              take;
  logic [DATA_W-1:0] rem_sub;
  logic [DATA_W-1:0] q_fin;
  logic [DATA_W-1:0] r_fin;

  always_comb begin
    a_neg = signed_div_i & opdata1_i[DATA_W-1];
    b_neg = signed_div_i & opdata2_i[DATA_W-1];
    a_mag = a_neg ? -opdata1_i : opdata1_i;
    b_mag = b_neg ? -opdata2_i : opdata2_i;
  end

  // The shifted partial remainder is DATA_W+1 bits; a set top bit always
  // exceeds the divisor, and the low bits wrap to the exact difference.
  always_comb begin
    rem_sh  = {rem, dvd[DATA_W-1]};
    take    = rem_sh[DATA_W] | (rem_sh[DATA_W-1:0] >= dsr);
    rem_sub = rem_sh[DATA_W-1:0] - dsr;
    q_fin   = neg_q ? -dvd : dvd;
    r_fin   = neg_r ? -rem : rem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FREE;
      cnt      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      unique case (state)
        S_FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= S_BYZERO;
            end else begin
              state <= S_ON;
              cnt   <= '0;
              dvd   <= a_mag;
              dsr   <= b_mag;
              rem   <= '0;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
            end
          end
        end
        S_BYZERO: begin
          state    <= S_END;
          result_o <= '0;
          ready_o  <= 1'b1;
        end
        S_ON: begin
          if (annul_i) begin
            state    <= S_FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else if (cnt != LAST) begin
            rem <= take ? rem_sub : rem_sh[DATA_W-1:0];
            dvd <= {dvd[DATA_W-2:0], take};
            cnt <= cnt + CNT_W'(1);
          end else begin
            state    <= S_END;
            result_o <= {r_fin, q_fin};
            ready_o  <= 1'b1;
          end
        end
        S_END: begin
          if (!start_i) begin
            state    <= S_FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: state <= S_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: vector table plus
// annul, reset and accept-timing sequences.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_seq #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Starts at posedge+1 with the block idle; operands are scrambled
  // after the accept edge to show they are not re-sampled.
  task automatic run_op(input logic s, input logic [31:0] a,
                        input logic [31:0] b,
                        output logic [63:0] res, output int lat);
    signed_div = s;
    op1 = a;
    op2 = b;
    start = 1'b1;
    step();
    lat = 0;
    while (!ready && lat < 60) begin
      op1 = $urandom;
      op2 = $urandom;
      signed_div = 1'($urandom_range(0, 1));
      step();
      lat++;
    end
    res = result;
  endtask

  task automatic full_op(input string name, input logic s,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r,
                         input int lat_exp);
    logic [63:0] res;
    int lat;
    run_op(s, a, b, res, lat);
    chk({name, " latency"}, 64'(lat), 64'(lat_exp));
    chk({name, " result"}, res, {r, q});
    step();
    step();
    chk({name, " hold ready"}, 64'(ready), 64'd1);
    chk({name, " hold result"}, result, {r, q});
    start = 1'b0;
    step();
    chk({name, " drop ready"}, 64'(ready), 64'd0);
    chk({name, " drop result"}, result, 64'd0);
  endtask

  initial begin
    logic [63:0] res;
    int lat;

    vt[0]  = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        33};
    vt[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 33};
    vt[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        33};
    vt[3]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 33};
    vt[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0,        33};
    vt[5]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE, 32'd1,        32'd1,        33};
    vt[6]  = '{1'b0, 32'd5,          32'd10,       32'd0,        32'd5,        33};
    vt[7]  = '{1'b0, 32'h12345678,   32'h100,      32'h00123456, 32'h78,       33};
    vt[8]  = '{1'b1, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 33};
    vt[9]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,        32'd0,        33};
    vt[10] = '{1'b1, 32'd100,        32'd0,        32'd0,        32'd0,        1};
    vt[11] = '{1'b0, 32'd0,          32'd0,        32'd0,        32'd0,        1};

    rst = 1'b1;
    start = 1'b0;
    annul = 1'b0;
    signed_div = 1'b0;
    op1 = '0;
    op2 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset ready", 64'(ready), 64'd0);
    chk("reset result", result, 64'd0);

    for (int i = 0; i < 12; i++) begin
      full_op($sformatf("vec%0d", i), vt[i].sgn, vt[i].a, vt[i].b,
              vt[i].q, vt[i].r, vt[i].lat);
    end

    // annul after ten steps, then a fresh op two cycles later
    signed_div = 1'b0;
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    step();
    repeat (10) step();
    annul = 1'b1;
    start = 1'b0;
    step();
    annul = 1'b0;
    chk("annul ready", 64'(ready), 64'd0);
    chk("annul result", result, 64'd0);
    step();
    chk("annul idle ready", 64'(ready), 64'd0);
    full_op("post annul", 1'b0, 32'hFFFFFFFF, 32'd1,
            32'hFFFFFFFF, 32'd0, 33);

    // reset in the middle of an operation
    signed_div = 1'b1;
    op1 = 32'hFFFFFFF9;
    op2 = 32'd2;
    start = 1'b1;
    step();
    repeat (20) step();
    rst = 1'b1;
    start = 1'b0;
    step();
    rst = 1'b0;
    chk("mid rst ready", 64'(ready), 64'd0);
    chk("mid rst result", result, 64'd0);
    full_op("post rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);

    // annul with start in FREE must not accept
    signed_div = 1'b0;
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    annul = 1'b1;
    step();
    annul = 1'b0;
    run_op(1'b0, 32'd100, 32'd7, res, lat);
    chk("annul-free latency", 64'(lat), 64'd33);
    chk("annul-free result", res, {32'd2, 32'd14});
    start = 1'b0;
    step();

    // divide-by-zero in FREE while annul asserted is also blocked
    op2 = 32'd0;
    start = 1'b1;
    annul = 1'b1;
    step();
    step();
    chk("annul byzero ready", 64'(ready), 64'd0);
    annul = 1'b0;
    start = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
